multi_cycle_mips: RTL and testbench

Multi-cycle MIPS-I subset core: the successor to the single-cycle datapath. Each instruction executes as a sequence of FETCH/DECODE/EXEC/MEM/WB states, so one ALU and one unified memory port are shared across cycles. The memory port has a req/ready handshake, so wait-state memories work. The reset PC and address width are parameters, and retire/halt status is exported for the bench and the top level.

---
 rtl/multi_cycle_mips_pkg.sv | 81 ++++++++
 rtl/multi_cycle_mips_regfile.sv | 30 +++
 rtl/multi_cycle_mips.sv | 160 ++++++++++++++++
 tb/tb_multi_cycle_mips.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_mips_pkg.sv
`default_nettype none
// ============================================================================
// multi_cycle_mips_pkg : opcodes, FSM states, ALU ops and decode helpers.
// Optional feature macro: MULTI_CYCLE_MIPS_BNE_EN (adds bne, opcode 0x05).
// Revision: 1.0
// ============================================================================
package multi_cycle_mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  function automatic logic insn_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                     (fn == FN_OR)  || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
`ifdef MULTI_CYCLE_MIPS_BNE_EN
      OP_BNE: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
    alu_op_e op;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_mips_regfile.sv
`default_nettype none
// ============================================================================
// mc_regfile : 32x32 register file, two async read ports, one sync write port.
// Revision: 1.0
// ============================================================================
module mc_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs_q [32];

  // No reset: contents are undefined until software writes them.
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs_q[raddr_b];

endmodule
`default_nettype wire

// File: rtl/multi_cycle_mips.sv
`default_nettype none
// ============================================================================
// multi_cycle_mips : multi-cycle MIPS-I subset core with a shared memory port.
// Optional feature macro: MULTI_CYCLE_MIPS_BNE_EN.   Revision: 1.0
// ============================================================================
module multi_cycle_mips
  import multi_cycle_mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [31:0]       pc_o,
  output logic              halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ipc_q, ipc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] tgt_q, tgt_d, alu_q, alu_d, mdr_q, mdr_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, rf_waddr;
  logic [31:0] imm_sext, rf_rdata_a, rf_rdata_b, alu_res, addr_full, rf_wdata;
  logic        req, we, ret, rf_we, acc, legal, is_rtype, is_mem, is_branch, take_branch;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
  assign legal    = insn_legal(opcode, funct);
  assign alu_res  = alu_calc(is_rtype ? funct_to_alu(funct) : ALU_ADD, a_q,
                             is_rtype ? b_q : imm_sext);
`ifdef MULTI_CYCLE_MIPS_BNE_EN
  assign is_branch   = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign take_branch = (opcode == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
  assign is_branch   = (opcode == OP_BEQ);
  assign take_branch = (a_q == b_q);
`endif

  // Outputs are forced quiet while reset is held, whatever the state register holds.
  assign mem_req   = rst & req;
  assign mem_we    = rst & we;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign retire    = rst & ret;
  assign halted    = rst & (state_q == S_HALT);
  assign pc_o      = !rst ? RESET_PC : ((state_q == S_FETCH) ? pc_q : ipc_q);
  assign acc       = mem_req & mem_ready;

  mc_regfile u_regfile (
    .clk     (clk),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (acc) state_d = S_DECODE;
      S_DECODE: state_d = !legal ? S_HALT : ((opcode == OP_J) ? S_FETCH : S_EXEC);
      S_EXEC: begin
        if (is_branch)   state_d = S_FETCH;
        else if (is_mem) state_d = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
        else             state_d = S_WB;
      end
      S_MEM:    if (acc) state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    req = 1'b0;  we = 1'b0;  ret = 1'b0;  addr_full = pc_q;
    rf_we = 1'b0;  rf_waddr = is_rtype ? rd : rt;
    rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
    pc_d = pc_q;  ipc_d = ipc_q;  ir_d = ir_q;  a_d = a_q;  b_d = b_q;
    tgt_d = tgt_q;  alu_d = alu_q;  mdr_d = mdr_q;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (acc) begin
          ir_d  = mem_rdata;
          ipc_d = pc_q;
          pc_d  = pc_q + 32'd4;
        end
      end
      S_DECODE: begin
        a_d   = rf_rdata_a;
        b_d   = rf_rdata_b;
        tgt_d = pc_q + (imm_sext << 2);
        if (opcode == OP_J) begin
          pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
          ret  = 1'b1;
        end
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (is_branch) begin
          if (take_branch) pc_d = tgt_q;
          ret = 1'b1;
        end
      end
      S_MEM: begin
        req       = 1'b1;
        we        = (opcode == OP_SW);
        addr_full = alu_q;
        if (acc) begin
          if (opcode == OP_SW) ret   = 1'b1;
          else                 mdr_d = mem_rdata;
        end
      end
      S_WB: begin
        rf_we = rst;
        ret   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      ipc_q <= RESET_PC;
    end else begin
      pc_q  <= pc_d;
      ipc_q <= ipc_d;
    end
    ir_q  <= ir_d;
    a_q   <= a_d;
    b_q   <= b_d;
    tgt_q <= tgt_d;
    alu_q <= alu_d;
    mdr_q <= mdr_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_mips.sv
`default_nettype none
// ============================================================================
// tb_multi_cycle_mips : scoreboard bench with an ISA-level reference model.
// Revision: 1.0
// ============================================================================
module tb_multi_cycle_mips;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;

  always #5 clk = ~clk;

  multi_cycle_mips #(.RESET_PC(RPC), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .pc_o(pc_o), .halted(halted)
  );

  // ---------------- memory with programmable wait states ----------------
  logic [31:0] mem [0:1023];
  logic [31:0] mm  [0:1023];
  int wait_mode, wait_q, pend_wait, cur_wait;
  bit in_acc;

  always_comb begin
    if (in_acc)              cur_wait = wait_q;
    else if (wait_mode == 1) cur_wait = (mem_addr < 32'h100) ? 2 : 0;
    else if (wait_mode == 2) cur_wait = pend_wait;
    else                     cur_wait = 0;
  end
  assign mem_ready = mem_req && (cur_wait == 0);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_req && !mem_ready) begin
      in_acc <= 1'b1;
      wait_q <= cur_wait - 1;
    end else begin
      in_acc <= 1'b0;
    end
    if (mem_req && mem_ready && mem_we) mem[mem_addr[11:2]] = mem_wdata;
    pend_wait <= $urandom_range(0, 2);
  end

  // ---------------- scoreboard ----------------
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_pc_q[$];
  logic [63:0] exp_wr_q[$];
  int ret_cyc[$];
  int cyc, dut_ret, exp_n;
  bit exp_halt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic        stall_prev;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;

  always @(negedge clk) begin
    logic [31:0] e;
    logic [63:0] w;
    if (rst) begin
      cyc = cyc + 1;
      if (cyc == 1) chk("first_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, RPC});
      if (retire) begin
        dut_ret = dut_ret + 1;
        ret_cyc.push_back(cyc);
        if (exp_pc_q.size() == 0) chk("extra_retire", 1, 0);
        else begin
          e = exp_pc_q.pop_front();
          chk("retire_pc", pc_o, e);
        end
      end
      if (mem_req && mem_ready && mem_we) begin
        if (exp_wr_q.size() == 0) chk("extra_write", {mem_addr, mem_wdata}, 0);
        else begin
          w = exp_wr_q.pop_front();
          chk("write", {mem_addr, mem_wdata}, w);
        end
      end
      if (halted) chk("halt_no_req", mem_req, 0);
      if (stall_prev && mem_req)
        chk("req_stable", {mem_we, mem_addr, mem_wdata}, {s_we, s_addr, s_wdata});
      stall_prev = mem_req && !mem_ready;
      s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- instruction encoders / program loading ----------------
  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] enc_j(input int idx);
    return {6'h02, idx[25:0]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; mm[i] = 32'd0; end
  endtask
  task automatic put(input int idx, input logic [31:0] w);
    mem[64 + idx] = w;
    mm[64 + idx]  = w;
  endtask

  // ISA interpreter: architectural state only, one instruction per step.
  task automatic model(input int max_ret);
    logic [31:0] r [32];
    logic [31:0] pc, npc, ins, a, b, simm, ea, wv;
    int wi, n;
    bit stop, hlt;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    pc = RPC; n = 0; stop = 0; exp_halt = 0;
    while (!stop && n < max_ret) begin
      ins  = mm[pc[11:2]];
      a    = r[ins[25:21]];
      b    = r[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      npc  = pc + 4; hlt = 0; wi = 0; wv = 0;
      case (ins[31:26])
        6'h00: begin
          wi = int'(ins[15:11]);
          case (ins[5:0])
            6'h20: wv = a + b;
            6'h22: wv = a - b;
            6'h24: wv = a & b;
            6'h25: wv = a | b;
            6'h2A: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: hlt = 1;
          endcase
        end
        6'h08: begin wi = int'(ins[20:16]); wv = a + simm; end
        6'h23: begin
          ea = a + simm;
          if (ea[1:0] != 0) hlt = 1;
          else begin wi = int'(ins[20:16]); wv = mm[ea[11:2]]; end
        end
        6'h2B: begin
          ea = a + simm;
          if (ea[1:0] != 0) hlt = 1;
          else begin mm[ea[11:2]] = b; exp_wr_q.push_back({ea, b}); end
        end
        6'h04: if (a == b) npc = pc + 4 + (simm << 2);
`ifdef MULTI_CYCLE_MIPS_BNE_EN
        6'h05: if (a != b) npc = pc + 4 + (simm << 2);
`endif
        6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
        default: hlt = 1;
      endcase
      if (hlt) begin
        exp_halt = 1; stop = 1;
      end else begin
        if (wi != 0) r[wi] = wv;
        exp_pc_q.push_back(pc);
        pc = npc;
        n++;
      end
    end
    exp_n = n;
  endtask

  task automatic run_test(input int max_ret, input int mode, input int budget);
    bit done;
    exp_pc_q.delete(); exp_wr_q.delete(); ret_cyc.delete();
    model(max_ret);
    wait_mode = mode;
    @(posedge clk); #1;
    cyc = 0; dut_ret = 0; rst = 1'b1;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #1;
      if (dut_ret >= exp_n && (!exp_halt || halted)) done = 1;
    end
    chk("completion", done, 1);
    if (exp_halt) begin
      repeat (6) @(posedge clk);
      #1 chk("halt_sticky", halted, 1);
    end
    chk("retire_count", dut_ret, exp_n);
    chk("writes_left", exp_wr_q.size(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {mem_req, mem_we, retire, halted, pc_o}, {4'b0000, RPC});
    @(posedge clk); #1;
  endtask

  task automatic gen_random(input int body);
    int last, i, t, off, k;
    clear_mem();
    for (int w = 16; w < 32; w++) begin mem[w] = $urandom; mm[w] = mem[w]; end
    last = 7 + body;
    for (int r = 1; r < 8; r++) put(r - 1, enc_i(6'h08, r, 0, int'($urandom_range(0, 65535))));
    for (i = 7; i < last; i++) begin
      k = $urandom_range(0, 8);
      case (k)
        0, 1, 2, 3: begin
          case ($urandom_range(0, 4))
            0: put(i, enc_r(6'h20, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
            1: put(i, enc_r(6'h22, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
            2: put(i, enc_r(6'h24, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
            3: put(i, enc_r(6'h25, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
            default: put(i, enc_r(6'h2A, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
          endcase
        end
        4: put(i, enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), int'($urandom_range(0, 65535))));
        5: put(i, enc_i(6'h23, $urandom_range(0, 7), 0, 32'h40 + 4 * int'($urandom_range(0, 15))));
        6: put(i, enc_i(6'h2B, $urandom_range(0, 7), 0, 32'h40 + 4 * int'($urandom_range(0, 15))));
        7: begin
          off = int'($urandom_range(0, 6)) - 2;
          t = i + 1 + off;
          if (t < 0 || t > last) off = 0;
          put(i, enc_i(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), off));
        end
        default: put(i, enc_j(64 + int'($urandom_range(7, last))));
      endcase
    end
    put(last, enc_j(64));
  endtask

  initial begin
    wait_mode = 0; cyc = 0; dut_ret = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {mem_req, mem_we, retire, halted, pc_o}, {4'b0000, RPC});

    // Arithmetic, then a store/load pair with two wait cycles on each data access.
    clear_mem();
    put(0, enc_i(6'h08, 1, 0, 5));
    put(1, enc_i(6'h08, 2, 0, -3));
    put(2, enc_r(6'h20, 3, 1, 2));
    put(3, enc_r(6'h2A, 4, 2, 1));
    put(4, enc_i(6'h2B, 3, 0, 32'h40));
    put(5, enc_i(6'h23, 5, 0, 32'h40));
    put(6, enc_i(6'h2B, 5, 0, 32'h44));
    put(7, enc_i(6'h2B, 4, 0, 32'h48));
    put(8, 32'hFC00_0000);
    run_test(20, 1, 400);
    chk("four_retires_cycle", ret_cyc[3], 16);
    chk("mem_0x40", mem[16], 32'd2);
    chk("lw_result_0x44", mem[17], 32'd2);
    chk("slt_result_0x48", mem[18], 32'd1);

    // Self-branch: re-fetches the same PC every 3 cycles.
    clear_mem();
    put(0, enc_i(6'h08, 1, 0, 7));
    put(1, enc_i(6'h04, 1, 1, -1));
    run_test(6, 0, 200);
    chk("addi_retire_cycle", ret_cyc[0], 4);
    for (int k = 2; k < 6; k++) chk("beq_period", ret_cyc[k] - ret_cyc[k-1], 3);

    // Untaken beq falls through; j takes 2 cycles.
    clear_mem();
    put(0, enc_i(6'h08, 1, 0, 1));
    put(1, enc_i(6'h08, 2, 0, 2));
    put(2, enc_i(6'h04, 2, 1, 1));
    put(3, enc_i(6'h2B, 1, 0, 32'h40));
    put(4, enc_j(64 + 6));
    put(5, enc_i(6'h2B, 2, 0, 32'h44));
    put(6, 32'hFC00_0000);
    run_test(20, 0, 200);
    chk("beq_cycles", ret_cyc[2] - ret_cyc[1], 3);
    chk("sw_cycles", ret_cyc[3] - ret_cyc[2], 4);
    chk("j_cycles", ret_cyc[4] - ret_cyc[3], 2);

    // Misaligned load traps after EXEC without a data request.
    clear_mem();
    put(0, enc_i(6'h23, 1, 0, 2));
    run_test(5, 0, 100);

    // Opcode 0x05: branch when enabled, trap otherwise.
    clear_mem();
    put(0, enc_i(6'h08, 1, 0, 1));
    put(1, enc_i(6'h05, 0, 1, 1));
    put(2, enc_i(6'h2B, 1, 0, 32'h40));
    put(3, enc_i(6'h2B, 1, 0, 32'h44));
    put(4, 32'hFC00_0000);
    run_test(20, 0, 200);

    // Random programs with random wait states.
    for (int s = 0; s < 5; s++) begin
      gen_random(40);
      run_test(80, 2, 3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
